alu_iter: RTL
=============

Name: alu_iter

Overview:
- Parametrised execute-stage ALU, successor to the single-cycle 32-bit ALU.
- Adds XOR, signed/unsigned compare, shifts, and iterative unsigned multiply/divide with a valid/ready handshake and a flush.
- Output is registered; results carry both ARM NZCV flags and the RISC-V zero flag.
- Sits in stage E and stalls the pipeline through ReadyE.

Parameters:
- WIDTH, 32, datapath width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width; local, derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ValidE  in  1  operation request
- ReadyE  out  1  block can accept a request this cycle
- FlushE  in  1  abort any in-flight operation
- ALUControlE  in  4  opcode
- Op1E  in  WIDTH  operand A
- Op2E  in  WIDTH  operand B
- ALUResultE  out  WIDTH  registered result
- ResultValidE  out  1  one-cycle pulse: ALUResultE, ALUFlags and ZeroE are valid
- ALUFlags  out  4  {N,Z,C,V} (ARM)
- ZeroE  out  1  result==0 (RISC-V)

Behaviour:
- Reset (async, reset_n=0): state IDLE, ReadyE=1, ResultValidE=0, ALUResultE=0, ALUFlags=0, ZeroE=1, internal counter/operands cleared.
- Reset deasserted mid-operation has no special case; the in-flight operation is lost.
- Accept: ValidE & ReadyE at a rising edge. ReadyE = (state==IDLE).
- ValidE while BUSY is ignored and is not queued.
- Opcodes, single-cycle (latency 1):
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt (signed), 0110 sltu
  - 0111 sll, 1000 srl, 1001 sra; shift amount = Op2E[SHW-1:0]
- Single-cycle result: result and flags registered at the accept edge, ResultValidE=1 the following cycle. State stays IDLE, so back-to-back accepts give one result per cycle.
- Opcodes, multi-cycle:
  - 1010 mul: low WIDTH bits of the product
  - 1011 mulhu: high WIDTH bits of the unsigned product
  - 1100 divu, 1101 remu: unsigned, restoring
- Multi-cycle sequencing:
  - Accept edge latches operands, counter=WIDTH, state BUSY.
  - Each subsequent edge performs one shift-add or restoring-subtract step and decrements the counter.
  - The edge at which the counter is 1 writes the result, pulses ResultValidE and returns to IDLE.
  - Latency: exactly WIDTH cycles from accept edge to ResultValidE.
  - ReadyE rises in the same cycle as ResultValidE, so a new op can be accepted then.
- Opcodes 1110 and 1111 are illegal: accepted, result 0, flags 0000, ZeroE=1, latency 1.
- Divide by zero: divu returns all-ones, remu returns Op1E. No trap; latency unchanged (WIDTH).
- Flags:
  - N = result MSB; Z = (result==0); ZeroE = Z for every op.
  - add: C = carry-out, V = signed overflow.
  - sub: computed as A + ~B + 1; C = carry-out (1 means no borrow, i.e. A>=B unsigned), V = signed overflow.
  - All other ops: C=0, V=0.
- Flush:
  - FlushE=1 at an edge forces IDLE and ResultValidE=0 next cycle; ALUResultE and ALUFlags hold their previous values.
  - FlushE together with ValidE: flush wins, the request is dropped.
  - FlushE in the same cycle a multi-cycle op would complete: the result is discarded, ResultValidE=0.
- ResultValidE is never high for two consecutive cycles due to a single op; it is high on consecutive cycles only for back-to-back single-cycle accepts.
- Outputs are held stable between results.

Test Plan:
1. WIDTH=32: add 0x7FFFFFFF+1 -> result 0x80000000, flags N=1 Z=0 C=0 V=1, ResultValidE one cycle after accept; sub 5-5 -> result 0, Z=1, C=1, ZeroE=1.
2. Back-to-back single-cycle ops (sra 0x80000000>>4, sltu 1<0xFFFFFFFF, xor 0xF0F0^0xFFFF) on three consecutive cycles -> 0xF8000000, 1, 0x0F0F on three consecutive ResultValidE cycles; ReadyE stays 1.
3. mul 0xFFFFFFFF*0xFFFFFFFF -> result 1, ResultValidE exactly 32 cycles after accept; mulhu same operands -> 0xFFFFFFFE. ReadyE=0 for cycles 1..31, and ValidE asserted during BUSY is ignored.
4. divu 100/7 -> 14 and remu 100/7 -> 2; divu x/0 -> 0xFFFFFFFF; remu 0x1234/0 -> 0x1234, each in 32 cycles.
5. FlushE at cycle 10 of a divu -> no ResultValidE, ReadyE=1 next cycle, ALUResultE unchanged; FlushE+ValidE same cycle -> no result. Flush on the completion cycle -> result dropped.
6. reset_n low asynchronously mid-mul -> ReadyE=1, ResultValidE=0, ALUResultE=0, ZeroE=1 immediately; then a WIDTH=8 build: mul 15*17 -> 0xFF in 8 cycles.

Source files
------------

// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative unsigned
// multiply/divide (one step per cycle), registered result with NZCV and zero flags.
module alu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ValidE,
  output logic             ReadyE,
  input  logic             FlushE,
  input  logic [3:0]       ALUControlE,
  input  logic [WIDTH-1:0] Op1E,
  input  logic [WIDTH-1:0] Op2E,
  output logic [WIDTH-1:0] ALUResultE,
  output logic             ResultValidE,
  output logic [3:0]       ALUFlags,
  output logic             ZeroE
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam logic [CW-1:0] CntOne  = CW'(1);
  localparam logic [CW-1:0] CntInit = CW'(WIDTH);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpXor   = 4'b0100;
  localparam logic [3:0] OpSlt   = 4'b0101;
  localparam logic [3:0] OpSltu  = 4'b0110;
  localparam logic [3:0] OpSll   = 4'b0111;
  localparam logic [3:0] OpSrl   = 4'b1000;
  localparam logic [3:0] OpSra   = 4'b1001;
  localparam logic [3:0] OpMul   = 4'b1010;
  localparam logic [3:0] OpMulhu = 4'b1011;
  localparam logic [3:0] OpDivu  = 4'b1100;
  localparam logic [3:0] OpRemu  = 4'b1101;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             zero_q, zero_d;
  logic             rvalid_q, rvalid_d;

  // Single-cycle datapath
  logic             is_sub, is_multi, is_mul_op;
  logic [WIDTH-1:0] b_eff, sc_res;
  logic [WIDTH:0]   sum;
  logic             sc_c, sc_v, sc_legal;
  logic [SHW-1:0]   shamt;

  always_comb begin
    is_sub    = (ALUControlE == OpSub);
    is_multi  = ALUControlE inside {OpMul, OpMulhu, OpDivu, OpRemu};
    is_mul_op = (ALUControlE == OpMul) || (ALUControlE == OpMulhu);
    b_eff     = is_sub ? ~Op2E : Op2E;
    sum       = {1'b0, Op1E} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt     = Op2E[SHW-1:0];
    sc_res    = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_legal  = 1'b1;
    case (ALUControlE)
      OpAdd, OpSub: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (Op1E[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != Op1E[WIDTH-1]);
      end
      OpAnd:   sc_res = Op1E & Op2E;
      OpOr:    sc_res = Op1E | Op2E;
      OpXor:   sc_res = Op1E ^ Op2E;
      OpSlt:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(Op1E) < $signed(Op2E))};
      OpSltu:  sc_res = {{(WIDTH-1){1'b0}}, (Op1E < Op2E)};
      OpSll:   sc_res = Op1E << shamt;
      OpSrl:   sc_res = Op1E >> shamt;
      OpSra:   sc_res = $unsigned($signed(Op1E) >>> shamt);
      default: sc_legal = 1'b0;
    endcase
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  // Multiply keeps {hi,lo} as the partial product; divide keeps remainder in hi, quotient in lo.
  logic [WIDTH:0]   mul_sum, div_rsh, div_diff;
  logic             div_ge, step_mul, take_lo;
  logic [WIDTH-1:0] hi_step, lo_step, mc_res;

  always_comb begin
    step_mul = (op_q == OpMul) || (op_q == OpMulhu);
    take_lo  = (op_q == OpMul) || (op_q == OpDivu);
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_rsh  = {hi_q, lo_q[WIDTH-1]};
    div_ge   = (div_rsh >= {1'b0, opd_q});
    div_diff = div_rsh - {1'b0, opd_q};
    if (step_mul) begin
      hi_step = mul_sum[WIDTH:1];
      lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_step = div_ge ? div_diff[WIDTH-1:0] : div_rsh[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], div_ge};
    end
    mc_res = take_lo ? lo_step : hi_step;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opd_d    = opd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    flags_d  = flags_q;
    zero_d   = zero_q;
    rvalid_d = 1'b0;
    if (FlushE) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      if (ValidE) begin
        if (is_multi) begin
          state_d = StBusy;
          cnt_d   = CntInit;
          op_d    = ALUControlE;
          hi_d    = '0;
          opd_d   = is_mul_op ? Op1E : Op2E;
          lo_d    = is_mul_op ? Op2E : Op1E;
        end else begin
          rvalid_d = 1'b1;
          res_d    = sc_res;
          zero_d   = ~|sc_res;
          flags_d  = sc_legal ? {sc_res[WIDTH-1], ~|sc_res, sc_c, sc_v} : 4'b0000;
        end
      end
    end else begin
      hi_d  = hi_step;
      lo_d  = lo_step;
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        state_d  = StIdle;
        rvalid_d = 1'b1;
        res_d    = mc_res;
        zero_d   = ~|mc_res;
        flags_d  = {mc_res[WIDTH-1], ~|mc_res, 2'b00};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      opd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      zero_q   <= 1'b1;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opd_q    <= opd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      zero_q   <= zero_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign ReadyE       = (state_q == StIdle);
  assign ALUResultE   = res_q;
  assign ResultValidE = rvalid_q;
  assign ALUFlags     = flags_q;
  assign ZeroE        = zero_q;

endmodule
